// File: rtl/usbf_fifo_pkg.sv
// usbf_fifo_pkg: shared defaults and pointer arithmetic for the USB packet FIFO.
package usbf_fifo_pkg;
   localparam int DEF_WIDTH  = 8;
   localparam int DEF_ADDR_W = 6;
   localparam int DEPTH      = 2**DEF_ADDR_W;
   localparam int PTR_MAX_W  = 17;
   typedef logic [PTR_MAX_W-1:0] ptr_t;
   // Distance a-b modulo 2**pw, where pw is the wrap-bit-extended pointer width.
   function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b, input int unsigned pw);
      ptr_t m;
      m = (ptr_t'(1) << pw) - ptr_t'(1);
      return (a - b) & m;
   endfunction
endpackage

// File: rtl/usbf_fifo_ram.sv
// usbf_fifo_ram: register-array storage, one synchronous write port, one asynchronous read port.
module usbf_fifo_ram
   import usbf_fifo_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk_i,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);
   logic [WIDTH-1:0] mem [2**ADDR_W];
   always_ff @(posedge clk_i) if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/usbf_pkt_fifo.sv
// usbf_pkt_fifo: packet-aware endpoint FIFO with commit/abort on write and commit/rewind on read.
module usbf_pkt_fifo
   import usbf_fifo_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              flush_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic              push_i,
   input  logic              wr_commit_i,
   input  logic              wr_abort_i,
   input  logic              pop_i,
   input  logic              rd_commit_i,
   input  logic              rd_rewind_i,
   output logic [WIDTH-1:0]  data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   wr_level_o,
   output logic [ADDR_W:0]   rd_avail_o,
   output logic              ovf_o
);
   localparam int PW = ADDR_W + 1;
   localparam int NW = 2**ADDR_W;
   logic [PW-1:0] wr_ptr, wr_cmt_ptr, rd_ptr, rd_cmt_ptr;
   logic [PW-1:0] wr_ptr_n, wr_cmt_n, rd_ptr_n, rd_cmt_n;
   logic          ovf_n, wr_drop, push_ok, pop_ok;
   assign wr_level_o = PW'(ptr_diff(ptr_t'(wr_ptr), ptr_t'(rd_cmt_ptr), PW));
   assign rd_avail_o = PW'(ptr_diff(ptr_t'(wr_cmt_ptr), ptr_t'(rd_ptr), PW));
   assign full_o     = wr_level_o == PW'(NW);
   assign empty_o    = rd_avail_o == '0;
   // A commit of an overflowed packet behaves exactly like an abort.
   assign wr_drop = wr_abort_i | (wr_commit_i & ovf_o);
   assign push_ok = push_i & ~full_o & ~flush_i & ~wr_drop;
   assign pop_ok  = pop_i & ~empty_o & ~flush_i & ~rd_rewind_i;
   always_comb begin
      wr_ptr_n = wr_drop ? wr_cmt_ptr : wr_ptr + PW'(push_ok);
      wr_cmt_n = (wr_commit_i & ~wr_drop) ? wr_ptr_n : wr_cmt_ptr;
      ovf_n    = (wr_commit_i | wr_abort_i) ? 1'b0 : ovf_o | (push_i & full_o);
      rd_ptr_n = rd_rewind_i ? rd_cmt_ptr : rd_ptr + PW'(pop_ok);
      rd_cmt_n = (rd_commit_i & ~rd_rewind_i) ? rd_ptr_n : rd_cmt_ptr;
   end
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr     <= '0;
         wr_cmt_ptr <= '0;
         rd_ptr     <= '0;
         rd_cmt_ptr <= '0;
         ovf_o      <= 1'b0;
      end else if (flush_i) begin
         wr_ptr     <= '0;
         wr_cmt_ptr <= '0;
         rd_ptr     <= '0;
         rd_cmt_ptr <= '0;
         ovf_o      <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_n;
         wr_cmt_ptr <= wr_cmt_n;
         rd_ptr     <= rd_ptr_n;
         rd_cmt_ptr <= rd_cmt_n;
         ovf_o      <= ovf_n;
      end
   end
   usbf_fifo_ram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_ram (
      .clk_i (clk_i),
      .we    (push_ok),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (data_i),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (data_o)
   );
endmodule

// File: tb/tb_usbf_pkt_fifo.sv
// tb_usbf_pkt_fifo: queue-based reference model of packet FIFO semantics, directed plus random stimulus.
module tb_usbf_pkt_fifo;
   localparam int D = 4;
   logic       clk_i = 0, rstn_i = 0, flush_i = 0, push_i = 0, wr_commit_i = 0, wr_abort_i = 0;
   logic       pop_i = 0, rd_commit_i = 0, rd_rewind_i = 0;
   logic [7:0] data_i = '0, data_o;
   logic       full_o, empty_o, ovf_o;
   logic [2:0] wr_level_o, rd_avail_o;
   int         vectors = 0, miscompares = 0;
   // q_rel: popped, not yet released; q_av: committed, unread; q_pd: pushed, not yet committed
   logic [7:0] q_rel[$], q_av[$], q_pd[$];
   bit         m_ovf;

   usbf_pkt_fifo #(.WIDTH(8), .ADDR_W(2)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i), .data_i(data_i), .push_i(push_i),
      .wr_commit_i(wr_commit_i), .wr_abort_i(wr_abort_i), .pop_i(pop_i),
      .rd_commit_i(rd_commit_i), .rd_rewind_i(rd_rewind_i), .data_o(data_o),
      .full_o(full_o), .empty_o(empty_o), .wr_level_o(wr_level_o),
      .rd_avail_o(rd_avail_o), .ovf_o(ovf_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk_i or negedge rstn_i) begin
      int  tot;
      bit  full0, empty0, ovf0;
      if (!rstn_i) begin
         q_rel.delete(); q_av.delete(); q_pd.delete(); m_ovf = 0;
      end else begin
         tot    = q_rel.size() + q_av.size() + q_pd.size();
         full0  = tot == D;
         empty0 = q_av.size() == 0;
         ovf0   = m_ovf;
         if (flush_i) begin
            q_rel.delete(); q_av.delete(); q_pd.delete(); m_ovf = 0;
         end else begin
            if (wr_abort_i || (wr_commit_i && ovf0)) begin
               q_pd.delete(); m_ovf = 0;
            end else if (wr_commit_i) begin
               if (push_i && !full0) q_pd.push_back(data_i);
               foreach (q_pd[i]) q_av.push_back(q_pd[i]);
               q_pd.delete(); m_ovf = 0;
            end else if (push_i) begin
               if (!full0) q_pd.push_back(data_i);
               else m_ovf = 1;
            end
            if (rd_rewind_i) begin
               q_av = {q_rel, q_av};
               q_rel.delete();
            end else begin
               if (pop_i && !empty0) q_rel.push_back(q_av.pop_front());
               if (rd_commit_i) q_rel.delete();
            end
         end
      end
   end

   always @(negedge clk_i) if (rstn_i) begin
      int tot;
      tot = q_rel.size() + q_av.size() + q_pd.size();
      chk("m_full", full_o, 32'(tot == D));
      chk("m_empty", empty_o, 32'(q_av.size() == 0));
      chk("m_wr_level", wr_level_o, tot);
      chk("m_rd_avail", rd_avail_o, q_av.size());
      chk("m_ovf", ovf_o, 32'(m_ovf));
      if (q_av.size() > 0) chk("m_data", data_o, q_av[0]);
   end

   task automatic cyc(input bit ps = 0, input logic [7:0] d = 0, input bit wc = 0, input bit wa = 0,
                      input bit pp = 0, input bit rc = 0, input bit rr = 0, input bit fl = 0);
      push_i = ps; data_i = d; wr_commit_i = wc; wr_abort_i = wa;
      pop_i = pp; rd_commit_i = rc; rd_rewind_i = rr; flush_i = fl;
      @(posedge clk_i);
      #2;
      push_i = 0; wr_commit_i = 0; wr_abort_i = 0; pop_i = 0;
      rd_commit_i = 0; rd_rewind_i = 0; flush_i = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #2;
      chk("rst_full", full_o, 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_level", wr_level_o, 0);
      chk("rst_avail", rd_avail_o, 0);
      chk("rst_ovf", ovf_o, 0);
      rstn_i = 1;
      // basic packet, pops, release
      cyc(.ps(1), .d(8'hA1)); cyc(.ps(1), .d(8'hA2)); cyc(.ps(1), .d(8'hA3)); cyc(.wc(1));
      chk("t1_avail", rd_avail_o, 3);
      chk("t1_empty", empty_o, 0);
      chk("t1_d0", data_o, 8'hA1);
      cyc(.pp(1)); chk("t1_d1", data_o, 8'hA2);
      cyc(.pp(1)); chk("t1_d2", data_o, 8'hA3);
      cyc(.pp(1));
      chk("t1_empty2", empty_o, 1);
      chk("t1_level", wr_level_o, 3);
      cyc(.rc(1)); chk("t1_level0", wr_level_o, 0);
      // abort of an uncommitted packet
      cyc(.ps(1), .d(8'h10)); cyc(.ps(1), .d(8'h11));
      chk("t2_empty", empty_o, 1);
      chk("t2_avail", rd_avail_o, 0);
      chk("t2_level", wr_level_o, 2);
      cyc(.wa(1)); chk("t2_abort", wr_level_o, 0);
      cyc(.ps(1), .d(8'h20), .wc(1));
      chk("t2_data", data_o, 8'h20);
      chk("t2_avail1", rd_avail_o, 1);
      cyc(.pp(1), .rc(1)); chk("t2_level0", wr_level_o, 0);
      // overflow turns commit into abort
      for (int i = 1; i <= 5; i++) cyc(.ps(1), .d(8'(i)));
      chk("t3_full", full_o, 1);
      chk("t3_ovf", ovf_o, 1);
      chk("t3_level", wr_level_o, 4);
      cyc(.wc(1));
      chk("t3_avail", rd_avail_o, 0);
      chk("t3_level0", wr_level_o, 0);
      chk("t3_ovf0", ovf_o, 0);
      // rewind for retransmit
      cyc(.ps(1), .d(8'hB0)); cyc(.ps(1), .d(8'hB1)); cyc(.ps(1), .d(8'hB2), .wc(1));
      repeat (3) cyc(.pp(1));
      cyc(.rr(1));
      chk("t4_data", data_o, 8'hB0);
      chk("t4_avail", rd_avail_o, 3);
      repeat (3) cyc(.pp(1));
      cyc(.rc(1)); chk("t4_level0", wr_level_o, 0);
      // simultaneous events
      cyc(.ps(1), .d(8'hC0)); cyc(.ps(1), .d(8'hC1), .wc(1));
      chk("t5_avail", rd_avail_o, 2);
      cyc(.pp(1)); chk("t5_d1", data_o, 8'hC1);
      cyc(.pp(1), .rr(1));
      chk("t5_rew_avail", rd_avail_o, 2);
      chk("t5_rew_data", data_o, 8'hC0);
      repeat (3) cyc(.ps(1), .d(8'hCC));
      chk("t5_ovf", ovf_o, 1);
      cyc(.ps(1), .d(8'hDD), .pp(1), .rc(1), .fl(1));
      chk("t5_fl_level", wr_level_o, 0);
      chk("t5_fl_avail", rd_avail_o, 0);
      chk("t5_fl_ovf", ovf_o, 0);
      chk("t5_fl_empty", empty_o, 1);
      // wrap through ten packets
      for (int k = 0; k < 10; k++) begin
         cyc(.ps(1), .d(8'(k*3))); cyc(.ps(1), .d(8'(k*3+1))); cyc(.ps(1), .d(8'(k*3+2)), .wc(1));
         for (int i = 0; i < 3; i++) begin
            chk("t6_data", data_o, 32'(k*3+i));
            chk("t6_full", full_o, 0);
            cyc(.pp(1), .rc(i == 2));
         end
         chk("t6_level", wr_level_o, 0);
      end
      // asynchronous reset mid-packet
      cyc(.ps(1), .d(8'h55)); cyc(.ps(1), .d(8'h66));
      rstn_i = 0;
      #1;
      chk("t6_rst_level", wr_level_o, 0);
      chk("t6_rst_empty", empty_o, 1);
      chk("t6_rst_full", full_o, 0);
      chk("t6_rst_ovf", ovf_o, 0);
      @(posedge clk_i); #2;
      rstn_i = 1;
      // randomized traffic
      for (int n = 0; n < 3000; n++)
         cyc(.ps($urandom_range(0, 9) < 6), .d(8'($urandom)), .wc($urandom_range(0, 19) < 3),
             .wa($urandom_range(0, 19) == 0), .pp($urandom_range(0, 1) == 1),
             .rc($urandom_range(0, 19) < 3), .rr($urandom_range(0, 19) == 0),
             .fl($urandom_range(0, 99) == 0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
